// File: rtl/jt49_dcout.sv
// jt49_dcout: decimate the PSG mix by 2^DECW, strip DC with an exponential
// averager, and present a signed left-justified sample over valid/ready.
module jt49_dcout #(
  parameter int DW    = 10,
  parameter int DECW  = 2,
  parameter int SHIFT = 8,
  parameter int OW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_stb,
  output logic [OW-1:0] dout,
  output logic          dout_vld,
  input  logic          dout_rdy,
  output logic          overrun
);
  localparam int DEC = 1 << DECW;
  localparam int SW  = DW + DECW;       // decimated sum width
  localparam int AW  = SW + SHIFT;      // averager state width (avg * 2^SHIFT)
  localparam int YW  = SW + 1;          // signed DC-removed width

  logic [SW-1:0]   sum;
  logic [DECW-1:0] cnt;
  logic [SW-1:0]   s;
  logic            s_vld;
  logic [AW-1:0]   acc;
  logic            first;
  logic [SW-1:0]   avg;
  logic [YW-1:0]   y;
  logic [SW-1:0]   sum_in;

  assign sum_in = sum + {{DECW{1'b0}}, din};
  assign avg    = acc[AW-1:SHIFT];

  // Box decimator: accumulate DEC strobes, hand the block sum to stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      cnt   <= '0;
      s     <= '0;
      s_vld <= 1'b0;
    end else begin
      s_vld <= 1'b0;
      if (din_stb) begin
        cnt <= cnt + 1'b1;
        if (cnt == DECW'(DEC - 1)) begin
          s     <= sum_in;
          s_vld <= 1'b1;
          sum   <= '0;
        end else begin
          sum <= sum_in;
        end
      end
    end
  end

  // DC-removed sample from the old average; zero on the preload block.
  always_comb begin
    y = '0;
    if (!first) y = {1'b0, s} - {1'b0, avg};
  end

  // Averager: preload on the first block so there is no startup transient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      first <= 1'b1;
    end else if (s_vld) begin
      if (first) begin
        acc   <= {s, {SHIFT{1'b0}}};
        first <= 1'b0;
      end else begin
        acc <= acc + {{SHIFT{1'b0}}, s} - {{SHIFT{1'b0}}, avg};
      end
    end
  end

  // Output holding register: newest sample wins, unconsumed overwrite is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      overrun  <= 1'b0;
    end else if (s_vld) begin
      dout     <= OW'(y) << (OW - YW);
      dout_vld <= 1'b1;
      if (dout_vld && !dout_rdy) overrun <= 1'b1;
    end else if (dout_vld && dout_rdy) begin
      dout_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jt49_dcout.sv
// Directed bench for jt49_dcout with default parameters.
`timescale 1ns/1ps
module tb_jt49_dcout;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  din;
  logic        din_stb;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_rdy;
  logic        overrun;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference averager state (spec arithmetic, used for the long settle run).
  int  m_acc;
  bit  m_first;
  int  m_y;

  jt49_dcout dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_stb(din_stb),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic m_push(input int sv);
    if (m_first) begin
      m_y = 0; m_acc = sv << 8; m_first = 0;
    end else begin
      m_y = sv - (m_acc >> 8);
      m_acc = m_acc + sv - (m_acc >> 8);
    end
  endtask

  function automatic logic [15:0] m_dout();
    return 16'(m_y * 8);
  endfunction

  task automatic strobe(input logic [9:0] v);
    din = v; din_stb = 1'b1;
    tick();
    din_stb = 1'b0; din = 10'($urandom);
  endtask

  // 4 strobes, then one edge so the stage-2 result is visible.
  task automatic block(input logic [9:0] v);
    for (int i = 0; i < 4; i++) strobe(v);
    tick();
    m_push(4 * int'(v));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #3; rst_n = 1'b1;
    m_first = 1; m_acc = 0;
  endtask

  initial begin
    logic [15:0] prev;
    int guard;
    rst_n = 1'b0; din = '0; din_stb = 1'b0; dout_rdy = 1'b0;
    m_first = 1; m_acc = 0; m_y = 0;

    // Reset with random activity on the inputs
    for (int i = 0; i < 5; i++) begin
      din = 10'($urandom); din_stb = 1'($urandom); tick();
    end
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_vld", 32'(dout_vld), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    din_stb = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_dout", 32'(dout), 32'h0);
    chk("idle_vld", 32'(dout_vld), 32'h0);

    // First block preload, 2-clock latency
    dout_rdy = 1'b1;
    for (int i = 0; i < 4; i++) strobe(10'd100);
    chk("lat_early", 32'(dout_vld), 32'h0);
    tick(); m_push(400);
    chk("pre_vld", 32'(dout_vld), 32'h1);
    chk("pre_dout", 32'(dout), 32'h0000);
    tick();
    chk("pre_drain", 32'(dout_vld), 32'h0);

    // Positive step and decay
    block(10'd200);
    chk("pos_dout", 32'(dout), 32'h0C80);
    block(10'd200);
    chk("pos2_dout", 32'(dout), 32'h0C78);   // avg 401 -> y 399
    block(10'd200);
    chk("pos3_dout", 32'(dout), 32'h0C68);   // avg 403 -> y 397
    prev = dout;
    guard = 0;
    while ((m_acc >> 8) != 800 && guard < 4000) begin
      block(10'd200);
      if (dout !== m_dout() || $signed(dout) > $signed(prev))
        chk("settle", 32'(dout), 32'(m_dout()));
      prev = dout;
      guard++;
    end
    chk("settle_bound", 32'(guard < 4000), 32'h1);
    chk("settle_last", 32'(dout), 32'(m_dout()));

    // Negative swing from avg 800
    block(10'd0);
    chk("neg_dout", 32'(dout), 32'hE700);
    chk("neg_ovr", 32'(overrun), 32'h0);
    tick();

    // Backpressure: two outputs with no accept
    dout_rdy = 1'b0;
    block(10'd0);
    chk("bp_a_vld", 32'(dout_vld), 32'h1);
    chk("bp_a_dout", 32'(dout), 32'(m_dout()));
    chk("bp_a_ovr", 32'(overrun), 32'h0);
    block(10'd300);
    chk("bp_b_dout", 32'(dout), 32'(m_dout()));
    chk("bp_b_ovr", 32'(overrun), 32'h1);
    chk("bp_b_vld", 32'(dout_vld), 32'h1);
    dout_rdy = 1'b1; tick(); dout_rdy = 1'b0;
    chk("bp_acc_vld", 32'(dout_vld), 32'h0);
    chk("bp_sticky", 32'(overrun), 32'h1);
    tick();
    chk("bp_sticky2", 32'(overrun), 32'h1);

    // Back-to-back 8 strobes, accept coincides with the new sample
    do_reset();
    tick();
    chk("rst_ovr_clr", 32'(overrun), 32'h0);
    for (int i = 0; i < 4; i++) strobe(10'd10);   // s = 40 -> preload
    for (int i = 0; i < 4; i++) strobe(10'd20);   // s = 80 -> y = 40
    chk("b2b_hold_vld", 32'(dout_vld), 32'h1);
    dout_rdy = 1'b1;
    tick();
    chk("b2b_vld", 32'(dout_vld), 32'h1);
    chk("b2b_dout", 32'(dout), 32'h0140);
    chk("b2b_ovr", 32'(overrun), 32'h0);
    tick();
    chk("b2b_drain", 32'(dout_vld), 32'h0);

    // Reset mid-block discards the partial sum
    strobe(10'd500); strobe(10'd500);
    do_reset();
    for (int i = 0; i < 3; i++) strobe(10'd50);
    tick();
    chk("mid_partial", 32'(dout_vld), 32'h0);
    strobe(10'd50);
    tick();
    chk("mid_vld", 32'(dout_vld), 32'h1);
    chk("mid_dout", 32'(dout), 32'h0000);
    tick();
    chk("mid_single", 32'(dout_vld), 32'h0);
    block(10'd50);
    chk("mid_next", 32'(dout), 32'h0000);
    chk("mid_ovr", 32'(overrun), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jt49_dcout.md
# jt49_dcout

Downstream output stage for the PSG core. It consumes the unsigned 10-bit combined `sound` word once per mix cycle and box-decimates it by 2^DECW. It removes the DC offset with a first-order exponential averager and delivers a signed, left-justified sample over a valid/ready handshake. Backpressure overrun is flagged rather than stalling the core.

## Interface
Parameters:
- `DW`, 10: input sample width (unsigned).
- `DECW`, 2: log2 of the decimation factor. DEC = 2^DECW input samples per output.
- `SHIFT`, 8: averager time constant, as a power of two (α = 2^-SHIFT).
- `OW`, 16: output width. Must satisfy OW ≥ DW+DECW+1.

Ports:
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `din`, in, DW: unsigned input sample. Qualified by `din_stb`.
- `din_stb`, in, 1: one-cycle strobe marking `din` valid. Strobes may occur on any cycle, including back-to-back cycles.
- `dout`, out, OW: signed, DC-removed, left-justified output sample.
- `dout_vld`, out, 1: `dout` holds an unconsumed sample.
- `dout_rdy`, in, 1: consumer accepts `dout` on a cycle where `dout_vld` and `dout_rdy` are both 1.
- `overrun`, out, 1: sticky flag, set when an unconsumed sample is overwritten.

## Operation
- **Decimator**
  - `sum` is DW+DECW bits wide and `cnt` is DECW bits wide.
  - On each `din_stb`: `cnt` increments and wraps.
  - If `cnt` ≠ DEC-1: `sum <= sum + din`.
  - If `cnt` = DEC-1: stage register `s <= sum + din`, `s_vld <= 1`, and `sum <= 0`.
  - `s_vld` is a one-cycle pulse.
- **DC averager**
  - `acc` is DW+DECW+SHIFT bits and holds avg·2^SHIFT; `avg = acc >> SHIFT`.
  - `first` is set by reset.
  - On `s_vld` with `first`=1: `acc <= s << SHIFT`, `y = 0`, and `first <= 0`. This preloads the averager so there is no startup transient.
  - On `s_vld` otherwise: `y = s − avg`, using the old `acc`. Then `acc <= acc + s − avg`.
  - `y` is signed, DW+DECW+1 bits. All arithmetic is exact; no saturation is needed.
- **Output register**
  - On `s_vld`: `dout <= {y, (OW−DW−DECW−1) zeros}` and `dout_vld <= 1`.
  - If `dout_vld`=1 and `dout_rdy`=0 in that same cycle, set `overrun <= 1`; the newest sample wins.
  - If `dout_vld`=1, `dout_rdy`=1 and there is no `s_vld`: `dout_vld <= 0`. `dout` keeps its value.
  - If a transfer and a new `s_vld` coincide: the new sample loads, `dout_vld` stays 1, and there is no overrun.
- **Reset values**: `sum`, `cnt`, `s`, `s_vld`, `acc`, `dout`, `dout_vld` and `overrun` are all 0; `first` = 1. Only `rst_n` clears `overrun`.
- **Reset mid-block**: partial sums are discarded. The next output needs a full DEC strobes and is preloaded again (output 0).

## Timing
- Latency is 2 clocks from the edge sampling the DEC-th `din_stb`:
  - edge t: `s` and `s_vld` register.
  - edge t+1: `dout` and `dout_vld` register, and `acc` updates.
  - `dout_vld` is observable after edge t+1.
- Throughput is one output per DEC strobes. The block is fully pipelined; a strobe during stage 2 activity is handled normally.
- There is no combinational path from `dout_rdy` to any output.
- `din` is ignored when `din_stb` is 0.

## Test plan
All scenarios use default parameters (DW=10, DECW=2, SHIFT=8, OW=16).
- **Reset.** Hold `rst_n`=0 with random `din`/`din_stb` → `dout`=0x0000, `dout_vld`=0, `overrun`=0. Release; no strobes → outputs stay at 0.
- **First block preload.** 4 strobes with `din`=100, `dout_rdy`=1 → `dout_vld` pulses 2 clocks after the 4th strobe with `dout`=0x0000. Internal avg = 400.
- **Positive step.** Continue with 4 strobes of `din`=200 → s=800, y=400, `dout`=0x0C80. Next avg = 401. Repeated blocks make `dout` decay monotonically toward 0.
- **Negative swing.** Settle with 300+ blocks at `din`=200 (avg=800), then 4 strobes of `din`=0 → y=−800, `dout`=0xE700.
- **Backpressure.**
  - Hold `dout_rdy`=0 across two output events (first value A, then B) → `dout`=B, `overrun`=1, `dout_vld`=1.
  - Raise `dout_rdy` for one cycle → `dout_vld`=0 next cycle, `overrun` stays 1.
  - Back-to-back strobes on 8 consecutive cycles, with an accept coinciding with the new sample → no overrun.
- **Reset mid-block.** 2 strobes of `din`=500, pulse `rst_n` low, then 4 strobes of `din`=50 → a single output, `dout`=0x0000 (preload). The prior partial sum has no effect; the following block at `din`=50 gives 0x0000.
